mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Single-port arbiter that shares the von Neumann instruction/data memory between the fetch stage and the load/store stage. It grants at most one memory access per cycle, applies the data-region base offset to data addresses, and routes the memory's one-cycle-latency read data back to the requester that issued the read. Data accesses have priority, and a run-length counter guarantees fetch forward progress. It sits between the pipeline front/back ends and a single-ported synchronous-read memory.

## Interface
- ADDR_W, 8, address width
- DATA_W, 8, data word width
- DATA_BASE, 8'd128, offset added to every data-port address, reads and writes alike
- MAX_D_RUN, 4, max consecutive data grants while fetch is waiting (1..15)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  ADDR_W  fetch address, raw with no offset
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  if_rdata valid this cycle
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address before offset
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  d_rdata valid this cycle (loads only)
- d_rdata  out  DATA_W  load data
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, registered inside memory, valid 1 cycle after address

## Operation
- Grant decision is combinational from the current requests and registered state. if_gnt and d_gnt are never both 1.
- Arbitration:
  - Only one requester active: that requester is granted.
  - Both active: d_gnt wins, unless run_cnt == MAX_D_RUN; then if_gnt wins.
- run_cnt (4 bits, registered):
  - Increments on each d_gnt cycle in which if_req = 1.
  - Clears on any if_gnt.
  - Clears on any cycle with if_req = 0.
  - Saturates at MAX_D_RUN.
- Memory drive:
  - if_gnt: mem_addr = if_addr, mem_we = 0.
  - d_gnt: mem_addr = (d_addr + DATA_BASE) mod 2^ADDR_W, mem_we = d_we, mem_wdata = d_wdata.
  - No grant: mem_we = 0; mem_addr and mem_wdata don't-care.
- Read-return tracking uses a registered owner state machine with states NONE, IF, D:
  - Next state is IF on if_gnt, D on a d_gnt load, NONE otherwise (stores, idle).
  - In state IF: if_rvalid = 1 and if_rdata = mem_rdata.
  - In state D: d_rvalid = 1 and d_rdata = mem_rdata.
  - In other states the rdata outputs are driven 0.
- Stores complete in the grant cycle. A store never produces d_rvalid.
- A store followed next cycle by a load to the same d_addr returns the new data, because the memory write lands on that clock edge.
- Requesters must not change address, data or d_we while req = 1 and gnt = 0. Behaviour otherwise is undefined.

## Timing
- Grant latency: 0 cycles. gnt is asserted in the same cycle as req when that requester wins.
- Read latency: rvalid asserts exactly 1 cycle after the grant cycle.
- Throughput: one access per cycle, back-to-back. Cycle N+1 may grant a new request while cycle N's read data returns.
- Worst-case fetch wait with both requesters continuously active: MAX_D_RUN data grants, then fetch is granted.
- Reset (rst_n = 0 sampled at a rising edge):
  - owner = NONE, run_cnt = 0.
  - if_gnt, d_gnt, mem_we are forced 0 combinationally while rst_n = 0.
  - All rvalid outputs are 0 and all rdata outputs are 0 in the cycle after the reset edge.
- Reset mid-read: a read granted in the cycle before the reset edge is dropped, with no rvalid. The requester must re-request.
- Data address wrap: d_addr = 8'd200 with DATA_BASE = 128 gives mem_addr = 8'd72.

## Test plan
- Fetch only: if_req = 1, if_addr = 0x05, memory word 0x05 = 0xA3 -> if_gnt = 1 in cycle 0; if_rvalid = 1 and if_rdata = 0xA3 in cycle 1; d_gnt stays 0.
- Data store then load: store d_addr = 0x10, d_wdata = 0x5C -> mem_addr = 0x90, mem_we = 1; next-cycle load of d_addr = 0x10 -> d_rvalid = 1 with d_rdata = 0x5C one cycle later; no d_rvalid after the store.
- Contention: if_req and d_req (loads) held high for 12 cycles, MAX_D_RUN = 4 -> grant pattern D D D D I D D D D I D D; rvalid follows each grant by 1 cycle; gnts never overlap.
- Starvation counter clear: 3 data grants with if_req = 1, then 1 cycle with if_req = 0, then both requesting -> 4 more data grants before fetch is granted.
- Address wrap: load d_addr = 0xC8 -> mem_addr = 0x48.
- Reset mid-operation: grant a fetch, assert rst_n = 0 at the next edge -> if_rvalid = 0, if_gnt = 0 and d_gnt = 0 during reset; run_cnt = 0 afterwards, so the first contested cycle grants data.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch vs. load/store with data priority,
// bounded fetch starvation and one-cycle read-data return routing.
module mem_port_arbiter #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] DATA_BASE = ADDR_W'(128),
  parameter int                MAX_D_RUN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam logic [3:0] RUN_MAX = 4'(MAX_D_RUN);

  owner_t     owner;
  owner_t     owner_next;
  logic [3:0] run_cnt;
  logic [3:0] run_cnt_next;

  // Owner of the in-flight read and the data-grant run length.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner   <= OWN_NONE;
      run_cnt <= 4'd0;
    end else begin
      owner   <= owner_next;
      run_cnt <= run_cnt_next;
    end
  end

  // Grant decision, memory drive, read-data routing and next state.
  always_comb begin
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    mem_addr     = {ADDR_W{1'b0}};
    mem_we       = 1'b0;
    mem_wdata    = {DATA_W{1'b0}};
    if_rvalid    = 1'b0;
    if_rdata     = {DATA_W{1'b0}};
    d_rvalid     = 1'b0;
    d_rdata      = {DATA_W{1'b0}};
    owner_next   = OWN_NONE;
    run_cnt_next = 4'd0;

    if (!rst_n) begin
      owner_next   = OWN_NONE;
      run_cnt_next = 4'd0;
    end else begin
      // Fetch wins only when alone or once data has used up its run.
      if (if_req && (!d_req || (run_cnt == RUN_MAX))) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end else begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
      end

      if (if_gnt) begin
        mem_addr   = if_addr;
        mem_we     = 1'b0;
        owner_next = OWN_IF;
      end else if (d_gnt) begin
        mem_addr   = d_addr + DATA_BASE;
        mem_we     = d_we;
        mem_wdata  = d_wdata;
        owner_next = d_we ? OWN_NONE : OWN_D;
      end else begin
        mem_we     = 1'b0;
        owner_next = OWN_NONE;
      end

      if (!if_req || if_gnt) begin
        run_cnt_next = 4'd0;
      end else if (d_gnt && (run_cnt != RUN_MAX)) begin
        run_cnt_next = run_cnt + 4'd1;
      end else begin
        run_cnt_next = run_cnt;
      end

      case (owner)
        OWN_IF: begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end
        OWN_D: begin
          d_rvalid = 1'b1;
          d_rdata  = mem_rdata;
        end
        default: begin
          if_rvalid = 1'b0;
          d_rvalid  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter with a behavioural
// synchronous-read memory attached to the memory port.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [7:0] if_addr = 8'h00, d_addr = 8'h00, d_wdata = 8'h00;
  logic       if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we;
  logic [7:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [7:0] mem_rdata;
  logic [7:0] mem [256];

  int  n_chk  = 0;
  int  n_pass = 0;
  byte prev_g = "-";

  typedef struct {
    string      name;
    logic       rst_n, if_req;
    logic [7:0] if_addr;
    logic       d_req, d_we;
    logic [7:0] d_addr, d_wdata;
    logic       e_if_gnt, e_d_gnt, e_mem_we, chk_addr;
    logic [7:0] e_mem_addr;
    logic       e_if_rvalid;
    logic [7:0] e_if_rdata;
    logic       e_d_rvalid;
    logic [7:0] e_d_rdata;
  } vec_t;

  vec_t tbl [12];

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory with registered read; known words are preloaded while in reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[8'h05] <= 8'hA3;
      mem[8'h07] <= 8'h71;
      mem[8'h48] <= 8'h3C;
      mem[8'h7F] <= 8'h9E;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  function automatic vec_t mk(string nm, logic rs, logic ir, logic [7:0] ia,
                              logic dr, logic dw, logic [7:0] da, logic [7:0] dd,
                              logic eig, logic edg, logic ewe, logic ca, logic [7:0] ema,
                              logic eiv, logic [7:0] eid, logic edv, logic [7:0] edd);
    vec_t v;
    v.name = nm; v.rst_n = rs; v.if_req = ir; v.if_addr = ia;
    v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
    v.e_if_gnt = eig; v.e_d_gnt = edg; v.e_mem_we = ewe; v.chk_addr = ca;
    v.e_mem_addr = ema; v.e_if_rvalid = eiv; v.e_if_rdata = eid;
    v.e_d_rvalid = edv; v.e_d_rdata = edd;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic [21:0] got, exp;
    @(posedge clk);
    #1;
    rst_n = v.rst_n; if_req = v.if_req; if_addr = v.if_addr;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    @(negedge clk);
    got = {if_gnt, d_gnt, mem_we, if_rvalid, if_rdata, d_rvalid, d_rdata};
    exp = {v.e_if_gnt, v.e_d_gnt, v.e_mem_we, v.e_if_rvalid, v.e_if_rdata,
           v.e_d_rvalid, v.e_d_rdata};
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: gnt/we/rv/rd got %h required %h", v.name, got, exp);
    if (v.chk_addr) begin
      n_chk++;
      if (mem_addr === v.e_mem_addr) n_pass++;
      else $display("FAIL %s mem_addr: got %h required %h", v.name, mem_addr, v.e_mem_addr);
    end
    if (v.e_mem_we) begin
      n_chk++;
      if (mem_wdata === v.d_wdata) n_pass++;
      else $display("FAIL %s mem_wdata: got %h required %h", v.name, mem_wdata, v.d_wdata);
    end
    if (!v.rst_n) prev_g = "-";
    else if (v.e_if_gnt) prev_g = "I";
    else if (v.e_d_gnt && !v.d_we) prev_g = "D";
    else prev_g = "-";
  endtask

  // req chars: B both, I fetch only, D load only, N none; grant chars: I, D, -.
  task automatic contend(input string nm, input string gpat, input string rpat);
    vec_t v;
    byte  g, r;
    for (int k = 0; k < gpat.len(); k++) begin
      g = gpat[k];
      r = rpat[k];
      v = mk($sformatf("%s[%0d]", nm, k), 1'b1,
             (r == "B") || (r == "I"), 8'h07,
             (r == "B") || (r == "D"), 1'b0, 8'h10, 8'h00,
             g == "I", g == "D", 1'b0, g != "-", (g == "I") ? 8'h07 : 8'h90,
             prev_g == "I", (prev_g == "I") ? 8'h71 : 8'h00,
             prev_g == "D", (prev_g == "D") ? 8'h5C : 8'h00);
      apply(v);
    end
  endtask

  initial begin
    tbl[0]  = mk("rst_hold",  1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 8'h10, 8'hAA,
                 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    tbl[1]  = mk("rst_idle",  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00,
                 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    tbl[2]  = mk("post_rst",  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00,
                 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    tbl[3]  = mk("fetch",     1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00,
                 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 8'h00);
    tbl[4]  = mk("fetch_rd",  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00,
                 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA3, 1'b0, 8'h00);
    tbl[5]  = mk("store",     1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 8'h5C,
                 1'b0, 1'b1, 1'b1, 1'b1, 8'h90, 1'b0, 8'h00, 1'b0, 8'h00);
    tbl[6]  = mk("ld_after_st", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00,
                 1'b0, 1'b1, 1'b0, 1'b1, 8'h90, 1'b0, 8'h00, 1'b0, 8'h00);
    tbl[7]  = mk("ld_rd",     1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00,
                 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h5C);
    tbl[8]  = mk("wrap_ld",   1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hC8, 8'h00,
                 1'b0, 1'b1, 1'b0, 1'b1, 8'h48, 1'b0, 8'h00, 1'b0, 8'h00);
    tbl[9]  = mk("wrap_rd",   1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00,
                 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3C);
    tbl[10] = mk("top_ld",    1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00,
                 1'b0, 1'b1, 1'b0, 1'b1, 8'h7F, 1'b0, 8'h00, 1'b0, 8'h00);
    tbl[11] = mk("top_rd",    1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00,
                 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h9E);

    for (int i = 0; i < 12; i++) apply(tbl[i]);

    contend("contend", "DDDDIDDDDIDD", "BBBBBBBBBBBB");
    contend("starve",  "-DDDDDDDDI",   "NBBBDBBBBB");

    // Saturated run counter must be cleared by reset.
    contend("pre_rst", "-DDDD", "NBBBB");
    apply(mk("rst_mid_d", 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 8'h10, 8'h00,
             1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00));
    contend("post_rst_d", "D-", "BN");

    // A fetch granted just before reset never returns data.
    contend("fetch_pre", "I", "I");
    apply(mk("rst_mid_if", 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 8'h10, 8'h00,
             1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00));
    contend("post_rst_if", "-", "N");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
